atan2_arbiter: RTL and testbench

ATAN2_ARBITER -- requirements
Module: atan2_arbiter

---
 rtl/atan2_arbiter_if.sv | 44 ++++
 rtl/atan2_arbiter.sv | 133 +++++++++++++
 tb/tb_atan2_arbiter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/atan2_arbiter_if.sv
// atan2_arbiter_if: bundles the requester-side and Arctan2-unit-side signals
// of atan2_arbiter so they travel as one port.
//   slave  : arbiter view (takes requests/results, drives done/angle/unit ctrl)
//   master : environment view (requesters plus the shared Arctan2 unit)
// Signals:
//   req[1:0]             level request per requester
//   arg1_0/arg2_0        requester 0 operands (y, x as IEEE-754 double)
//   arg1_1/arg2_1        requester 1 operands
//   done[1:0]            one-cycle completion pulse to the served requester
//   angle[12:0]          signed Q3.10 result, held until the next done
//   err                  result came from a unit timeout
//   busy                 arbiter not idle
//   atan_arg1/atan_arg2  operands to the shared unit
//   atan_enable          one-cycle start pulse to the unit
//   atan_reset           active-high reset to the unit
//   atan_angle           unit result
//   atan_ready           unit result valid
interface atan2_arbiter_if;
  logic        [1:0]  req;
  logic        [63:0] arg1_0;
  logic        [63:0] arg2_0;
  logic        [63:0] arg1_1;
  logic        [63:0] arg2_1;
  logic        [1:0]  done;
  logic signed [12:0] angle;
  logic               err;
  logic               busy;
  logic        [63:0] atan_arg1;
  logic        [63:0] atan_arg2;
  logic               atan_enable;
  logic               atan_reset;
  logic signed [12:0] atan_angle;
  logic               atan_ready;

  modport slave (
    input  req, arg1_0, arg2_0, arg1_1, arg2_1, atan_angle, atan_ready,
    output done, angle, err, busy, atan_arg1, atan_arg2, atan_enable, atan_reset
  );

  modport master (
    output req, arg1_0, arg2_0, arg1_1, arg2_1, atan_angle, atan_ready,
    input  done, angle, err, busy, atan_arg1, atan_arg2, atan_enable, atan_reset
  );
endinterface

// File: rtl/atan2_arbiter.sv
// atan2_arbiter: shares one Arctan2 unit between two requesters with
// round-robin arbitration, a WAIT watchdog and a unit-reset recovery path.
// Ports:
//   clk    single clock, rising edge
//   reset  asynchronous, active-low
//   bus    atan2_arbiter_if.slave (requests, operands, results, unit control)
// Parameters:
//   TIMEOUT     max WAIT cycles before the unit is declared hung
//   RST_CYCLES  cycles atan_reset is held high during recovery (>= 1)
module atan2_arbiter #(
  parameter int unsigned TIMEOUT    = 32,
  parameter int unsigned RST_CYCLES = 2
) (
  input  logic           clk,
  input  logic           reset,
  atan2_arbiter_if.slave bus
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned RW = $clog2(RST_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RCNT_LAST  = RW'(RST_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, RECOVER} state_t;

  state_t             state, state_nxt;
  logic               grant, grant_nxt;
  logic               last;          // requester served most recently
  logic        [63:0] hold1, hold2;
  logic [TW-1:0]      timer;
  logic [RW-1:0]      rcnt;
  logic signed [12:0] angle_q;
  logic               err_q;
  logic               atan_rst_q;
  logic        [1:0]  done_c;
  logic               enable_c;
  logic               timer_last;

  assign timer_last = (timer == TIMER_LAST);

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    done_c    = '0;
    enable_c  = 1'b0;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          state_nxt = ISSUE;
          case (bus.req)
            2'b01:   grant_nxt = 1'b0;
            2'b10:   grant_nxt = 1'b1;
            default: grant_nxt = ~last;
          endcase
        end
      end
      ISSUE: begin
        enable_c  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        // ready on the final watchdog cycle still counts as a normal result
        if (bus.atan_ready)   state_nxt = DONE;
        else if (timer_last)  state_nxt = RECOVER;
      end
      RECOVER: begin
        if (rcnt == RCNT_LAST) state_nxt = DONE;
      end
      DONE: begin
        done_c[grant] = 1'b1;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last       <= 1'b1;   // makes requester 0 win the first tie
      hold1      <= '0;
      hold2      <= '0;
      timer      <= '0;
      rcnt       <= '0;
      angle_q    <= '0;
      err_q      <= 1'b0;
      atan_rst_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      // registered so it is high throughout reset and exactly in RECOVER
      atan_rst_q <= (state_nxt == RECOVER);
      case (state)
        IDLE: begin
          if (|bus.req) begin
            grant <= grant_nxt;
            hold1 <= grant_nxt ? bus.arg1_1 : bus.arg1_0;
            hold2 <= grant_nxt ? bus.arg2_1 : bus.arg2_0;
          end
        end
        ISSUE: timer <= '0;
        WAIT: begin
          timer <= timer + TW'(1);
          if (bus.atan_ready) begin
            angle_q <= bus.atan_angle;
            err_q   <= 1'b0;
          end else if (timer_last) begin
            rcnt <= '0;
          end
        end
        RECOVER: begin
          rcnt <= rcnt + RW'(1);
          if (rcnt == RCNT_LAST) begin
            angle_q <= '0;
            err_q   <= 1'b1;
          end
        end
        DONE: last <= grant;
        default: ;
      endcase
    end
  end

  assign bus.done        = done_c;
  assign bus.angle       = angle_q;
  assign bus.err         = err_q;
  assign bus.busy        = (state != IDLE);
  assign bus.atan_arg1   = hold1;
  assign bus.atan_arg2   = hold2;
  assign bus.atan_enable = enable_c;
  assign bus.atan_reset  = atan_rst_q;

endmodule

// File: tb/tb_atan2_arbiter.sv
// tb_atan2_arbiter: table-driven and hand-sequenced checks of atan2_arbiter
// with a behavioural Arctan2 unit model and a done/angle/err scoreboard.
module tb_atan2_arbiter;
  localparam int TIMEOUT    = 32;
  localparam int RST_CYCLES = 2;

  logic clk = 1'b0;
  logic reset;

  atan2_arbiter_if bus();

  atan2_arbiter #(.TIMEOUT(TIMEOUT), .RST_CYCLES(RST_CYCLES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        [1:0]  done;
    logic signed [12:0] angle;
    logic               err;
  } exp_t;

  typedef struct {
    logic        [1:0]  req;
    int                 lat;     // unit latency after enable, -1 = never
    logic signed [12:0] uval;    // unit result
    logic               grant;
    logic signed [12:0] eangle;
    logic               eerr;
    int                 edelay;  // cycles from enable to done
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[10];

  int n_checks = 0;
  int n_fail   = 0;

  int                 unit_lat = -1;
  logic signed [12:0] unit_val = '0;
  int                 ucnt     = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Arctan2 unit model: ready pulses unit_lat cycles after the enable cycle.
  always @(negedge clk) begin
    bus.atan_ready = 1'b0;
    bus.atan_angle = unit_val;
    if (bus.atan_enable) ucnt = unit_lat;
    else if (ucnt > 0) begin
      ucnt--;
      if (ucnt == 0) begin
        bus.atan_ready = 1'b1;
        ucnt = -1;
      end
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (bus.done !== 2'b00) begin
      chk("done_onehot", {63'b0, $onehot(bus.done)}, 64'd1);
      if (sb.size() == 0) chk("unexpected_done", bus.done, 64'd0);
      else begin
        mon_e = sb.pop_front();
        chk("sb_done",  bus.done,  mon_e.done);
        chk("sb_angle", bus.angle, mon_e.angle);
        chk("sb_err",   bus.err,   mon_e.err);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int done_at, en_at, rst_hi, ndone, gap, nd;
    bit counting;
    int gaps[$];
    logic [63:0] a10, a20, a11, a21, e1, e2, orig1, orig2;

    reset = 1'b1;
    bus.req = '0;
    bus.arg1_0 = '0; bus.arg2_0 = '0; bus.arg1_1 = '0; bus.arg2_1 = '0;

    // Reset state, applied asynchronously before any clock edge.
    #2 reset = 1'b0;
    #1;
    chk("rst_done",       bus.done,        64'd0);
    chk("rst_angle",      bus.angle,       64'd0);
    chk("rst_err",        bus.err,         64'd0);
    chk("rst_busy",       bus.busy,        64'd0);
    chk("rst_enable",     bus.atan_enable, 64'd0);
    chk("rst_atan_reset", bus.atan_reset,  64'd1);
    chk("rst_arg1",       bus.atan_arg1,   64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1 chk("atan_reset_before_edge", bus.atan_reset, 64'd1);
    @(negedge clk);
    chk("atan_reset_after_edge", bus.atan_reset, 64'd0);

    // Table-driven transactions; grants follow the round-robin from reset.
    vecs[0] = '{2'b01,  3,  13'sd100,  1'b0,  13'sd100,  1'b0,  4};
    vecs[1] = '{2'b10,  5, -13'sd200,  1'b1, -13'sd200,  1'b0,  6};
    vecs[2] = '{2'b11,  2,  13'sd300,  1'b0,  13'sd300,  1'b0,  3};
    vecs[3] = '{2'b11,  4, -13'sd1000, 1'b1, -13'sd1000, 1'b0,  5};
    vecs[4] = '{2'b01,  1,  13'sd7,    1'b0,  13'sd7,    1'b0,  2};
    vecs[5] = '{2'b11,  6,  13'sd4095, 1'b1,  13'sd4095, 1'b0,  7};
    vecs[6] = '{2'b10, 32, -13'sd4095, 1'b1, -13'sd4095, 1'b0, 33};
    vecs[7] = '{2'b11, 33,  13'sd55,   1'b0,  13'sd0,    1'b1, 35};
    vecs[8] = '{2'b01, -1,  13'sd99,   1'b0,  13'sd0,    1'b1, 35};
    vecs[9] = '{2'b11,  3,  13'sd12,   1'b1,  13'sd12,   1'b0,  4};

    for (int i = 0; i < 10; i++) begin
      a10 = {$urandom, $urandom}; a20 = {$urandom, $urandom};
      a11 = {$urandom, $urandom}; a21 = {$urandom, $urandom};
      e1 = vecs[i].grant ? a11 : a10;
      e2 = vecs[i].grant ? a21 : a20;
      @(negedge clk);
      bus.arg1_0 = a10; bus.arg2_0 = a20; bus.arg1_1 = a11; bus.arg2_1 = a21;
      bus.req  = vecs[i].req;
      unit_lat = vecs[i].lat;
      unit_val = vecs[i].uval;
      sb.push_back('{done: (vecs[i].grant ? 2'b10 : 2'b01), angle: vecs[i].eangle, err: vecs[i].eerr});
      en_at = -1; done_at = -1; rst_hi = 0;
      for (int c = 1; c <= 100 && done_at < 0; c++) begin
        @(negedge clk);
        if (bus.atan_enable) begin
          en_at = c;
          chk("vec_atan_arg1", bus.atan_arg1, e1);
          chk("vec_atan_arg2", bus.atan_arg2, e2);
        end
        if (bus.atan_reset) rst_hi++;
        if (bus.done != 2'b00) begin
          done_at = c;
          bus.req = '0;
        end
      end
      chk("vec_enable_cycle", en_at, 1);
      chk("vec_done_delay", done_at - en_at, vecs[i].edelay);
      chk("vec_atan_reset_cycles", rst_hi, vecs[i].eerr ? RST_CYCLES : 0);
    end

    // Latency: enable at cycle 1, done at cycle 22 for a 20-cycle unit.
    do_reset();
    @(negedge clk);
    bus.req = 2'b01;
    bus.arg1_0 = 64'h3FF0000000000000;
    bus.arg2_0 = 64'h3FF0000000000000;
    unit_lat = 20;
    unit_val = 13'sd804;
    sb.push_back('{done: 2'b01, angle: 13'sd804, err: 1'b0});
    done_at = -1;
    for (int c = 1; c <= 40 && done_at < 0; c++) begin
      @(negedge clk);
      if (c == 1) chk("lat_enable_c1", bus.atan_enable, 64'd1);
      if (bus.done != 2'b00) begin
        done_at = c;
        bus.req = '0;
      end
    end
    chk("lat_done_cycle", done_at, 22);

    // Both requesting across three transactions: order 0,1,0; one idle cycle between.
    do_reset();
    @(negedge clk);
    bus.req = 2'b11;
    unit_lat = 2;
    unit_val = 13'sd11;
    sb.push_back('{done: 2'b01, angle: 13'sd11, err: 1'b0});
    sb.push_back('{done: 2'b10, angle: 13'sd11, err: 1'b0});
    sb.push_back('{done: 2'b01, angle: 13'sd11, err: 1'b0});
    ndone = 0; gap = 0; counting = 1'b0;
    for (int c = 1; c <= 200 && ndone < 3; c++) begin
      @(negedge clk);
      if (counting) begin
        if (!bus.busy) gap++;
        else begin
          gaps.push_back(gap);
          counting = 1'b0;
        end
      end
      if (bus.done != 2'b00) begin
        ndone++;
        if (ndone < 3) begin
          counting = 1'b1;
          gap = 0;
        end else bus.req = '0;
      end
    end
    chk("rr_done_count", ndone, 3);
    chk("rr_gap_count", gaps.size(), 2);
    foreach (gaps[k]) chk("rr_idle_gap", gaps[k], 1);

    // Request dropped and operand changed after grant: computation unaffected.
    @(negedge clk);
    a11 = {$urandom, $urandom}; a21 = {$urandom, $urandom};
    bus.arg1_1 = a11; bus.arg2_1 = a21;
    orig1 = a11; orig2 = a21;
    bus.req = 2'b10;
    unit_lat = 10;
    unit_val = -13'sd5;
    sb.push_back('{done: 2'b10, angle: -13'sd5, err: 1'b0});
    done_at = -1;
    for (int c = 1; c <= 60 && done_at < 0; c++) begin
      @(negedge clk);
      if (c == 5) begin
        bus.req = '0;
        bus.arg1_1 = ~a11;
      end
      if (bus.busy) begin
        chk("drop_atan_arg1", bus.atan_arg1, orig1);
        chk("drop_atan_arg2", bus.atan_arg2, orig2);
      end
      if (bus.done != 2'b00) done_at = c;
    end
    chk("drop_done_cycle", done_at, 12);

    // Reset in WAIT cycle 10: outputs clear asynchronously, no done.
    @(negedge clk);
    bus.req = 2'b10;
    unit_lat = -1;
    unit_val = 13'sd0;
    repeat (11) @(negedge clk);
    chk("mid_busy_before", bus.busy, 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_done",       bus.done,        64'd0);
    chk("mid_angle",      bus.angle,       64'd0);
    chk("mid_err",        bus.err,         64'd0);
    chk("mid_busy",       bus.busy,        64'd0);
    chk("mid_enable",     bus.atan_enable, 64'd0);
    chk("mid_atan_reset", bus.atan_reset,  64'd1);
    chk("mid_arg1",       bus.atan_arg1,   64'd0);
    bus.req = '0;
    nd = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.done != 2'b00) nd++;
    end
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.done != 2'b00) nd++;
    end
    chk("mid_no_done", nd, 0);
    chk("mid_idle_after", bus.busy, 64'd0);
    bus.req = 2'b11;
    unit_lat = 3;
    unit_val = 13'sd21;
    sb.push_back('{done: 2'b01, angle: 13'sd21, err: 1'b0});
    done_at = -1;
    for (int c = 1; c <= 40 && done_at < 0; c++) begin
      @(negedge clk);
      if (bus.done != 2'b00) begin
        done_at = c;
        bus.req = '0;
      end
    end
    chk("mid_restart_done_cycle", done_at, 5);

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
